// File: rtl/hex_scan_ctrl_if.sv
// Bundle of the processor-facing PIO signals and the display-facing
// outputs of the seven-segment scan controller.
interface hex_scan_ctrl_if;
  logic       enable;
  logic [7:0] hex0_in;
  logic [7:0] hex1_in;
  logic [7:0] hex2_in;
  logic [7:0] hex3_in;
  logic [3:0] bright_in;
  logic [7:0] seg_out;
  logic [3:0] dig_out;
  logic       frame_tick;

  // Processor / PIO side: supplies patterns and brightness, observes outputs.
  modport master (
    output enable, hex0_in, hex1_in, hex2_in, hex3_in, bright_in,
    input  seg_out, dig_out, frame_tick
  );

  // Scan controller side.
  modport slave (
    input  enable, hex0_in, hex1_in, hex2_in, hex3_in, bright_in,
    output seg_out, dig_out, frame_tick
  );
endinterface

// File: rtl/hex_scan_ctrl.sv
// Four-digit seven-segment scan controller. Each digit gets a blanking gap
// (all digits off, segment bus already switched to the new pattern) followed
// by an ON phase split into 16 PWM slots. Digit patterns and brightness are
// captured once per frame so a frame never shows a half-updated display.
module hex_scan_ctrl #(
  parameter int DIGIT_CYCLES   = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic           clk_clk,
  input  logic           reset_reset,
  hex_scan_ctrl_if.slave bus
);

  localparam int SLOT_CYCLES = DIGIT_CYCLES / 16;
  localparam int PHASE_MAX   = (BLANK_CYCLES > SLOT_CYCLES) ? BLANK_CYCLES : SLOT_CYCLES;
  localparam int PW          = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;

  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);
  localparam logic [PW-1:0] SLOT_LAST  = PW'(SLOT_CYCLES - 1);

  // XOR masks that turn "1 = lit / selected" into pin polarity; the mask
  // itself is also the all-off pin value.
  localparam logic [7:0] SEG_INV = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [3:0] DIG_INV = (DIG_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [1:0]    digit_reg, digit_next;
  logic [PW-1:0] phase_reg, phase_next;
  logic [3:0]    slot_reg, slot_next;
  logic [3:0]    bright_snap_reg;
  logic [7:0]    snap_reg [4];
  logic [7:0]    seg_reg, seg_next;
  logic [3:0]    dig_reg, dig_next;
  logic          tick_reg, tick_next;
  logic          frame_start;
  logic [7:0]    seg_pattern;
  logic [7:0]    hex_in [4];

  assign hex_in[0] = bus.hex0_in;
  assign hex_in[1] = bus.hex1_in;
  assign hex_in[2] = bus.hex2_in;
  assign hex_in[3] = bus.hex3_in;

  // State, counters and registered outputs; reset drives pins inactive at once.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_reg <= IDLE;
      digit_reg <= 2'd0;
      phase_reg <= '0;
      slot_reg  <= 4'd0;
      seg_reg   <= SEG_INV;
      dig_reg   <= DIG_INV;
      tick_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      digit_reg <= digit_next;
      phase_reg <= phase_next;
      slot_reg  <= slot_next;
      seg_reg   <= seg_next;
      dig_reg   <= dig_next;
      tick_reg  <= tick_next;
    end
  end

  // Per-frame snapshot of patterns and brightness, taken only at frame start.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      bright_snap_reg <= 4'd0;
      for (int i = 0; i < 4; i++) snap_reg[i] <= 8'h00;
    end else if (frame_start) begin
      bright_snap_reg <= bus.bright_in;
      for (int i = 0; i < 4; i++) snap_reg[i] <= hex_in[i];
    end
  end

  // Next-state sequencing, then outputs derived from where the FSM lands
  // so the registered pins line up with the state they belong to.
  always_comb begin
    state_next  = state_reg;
    digit_next  = digit_reg;
    phase_next  = phase_reg + 1'b1;
    slot_next   = slot_reg;
    frame_start = 1'b0;
    tick_next   = 1'b0;
    seg_pattern = 8'h00;
    seg_next    = SEG_INV;
    dig_next    = DIG_INV;

    if (!bus.enable) begin
      state_next = IDLE;
      digit_next = 2'd0;
      phase_next = '0;
      slot_next  = 4'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next  = BLANK;
          digit_next  = 2'd0;
          phase_next  = '0;
          slot_next   = 4'd0;
          frame_start = 1'b1;
        end
        BLANK: begin
          if (phase_reg == BLANK_LAST) begin
            state_next = ON;
            phase_next = '0;
            slot_next  = 4'd0;
          end
        end
        ON: begin
          if (phase_reg == SLOT_LAST) begin
            phase_next = '0;
            if (slot_reg == 4'd15) begin
              state_next = BLANK;
              slot_next  = 4'd0;
              if (digit_reg == 2'd3) begin
                digit_next  = 2'd0;
                frame_start = 1'b1;
                tick_next   = 1'b1;
              end else begin
                digit_next = digit_reg + 2'd1;
              end
            end else begin
              slot_next = slot_reg + 4'd1;
            end
          end
        end
        default: begin
          state_next = IDLE;
          digit_next = 2'd0;
          phase_next = '0;
          slot_next  = 4'd0;
        end
      endcase
    end

    // At frame start the snapshot registers are still being written, so the
    // first digit's pattern comes straight from the input.
    seg_pattern = frame_start ? hex_in[0] : snap_reg[digit_next];
    if (state_next != IDLE) seg_next = seg_pattern ^ SEG_INV;
    if (state_next == ON && slot_next <= bright_snap_reg)
      dig_next = (4'b0001 << digit_next) ^ DIG_INV;
  end

  assign bus.seg_out    = seg_reg;
  assign bus.dig_out    = dig_reg;
  assign bus.frame_tick = tick_reg;

endmodule

// File: doc/hex_scan_ctrl.md
# hex_scan_ctrl

Time-multiplexed scan controller for a four-digit common-anode seven-segment display. It takes the four 8-bit hex digit patterns written by the processor through the PIO exports and drives them onto one shared segment bus with per-digit enables. It inserts a blanking gap between digits to suppress ghosting and applies a 16-level PWM brightness. It sits between the Nios PIO outputs and the board display pins.

## Interface
- DIGIT_CYCLES, 50000: length of each digit's ON phase in clocks; must be a multiple of 16 and at least 16.
- BLANK_CYCLES, 500: length of the all-digits-off gap before each digit, in clocks; at least 1.
- SEG_ACTIVE_LOW, 1: 1 inverts segment outputs, so a lit segment is driven 0.
- DIG_ACTIVE_LOW, 1: 1 means the selected digit is driven 0.
- clk_clk  in  1  system clock; the block's only clock.
- reset_reset  in  1  reset, asynchronous assert, active-high.
- enable  in  1  scan enable; 0 forces idle.
- hex0_in..hex3_in  in  8 each  digit patterns; bit7 = dp, bits6:0 = g..a; 1 = segment lit.
- bright_in  in  4  brightness level 0..15; digit on for (bright+1)/16 of ON phase.
- seg_out  out  8  shared segment bus, registered.
- dig_out  out  4  digit selects; bit i = digit i; registered.
- frame_tick  out  1  one-cycle pulse at end of each full frame, registered.

## Operation
- FSM states: IDLE, BLANK, ON. A 2-bit digit index selects the current digit.
- Reset or enable=0: state IDLE, digit index 0.
  - seg_out is inactive: 8'hFF if SEG_ACTIVE_LOW, else 8'h00.
  - dig_out is inactive: 4'hF if DIG_ACTIVE_LOW, else 4'h0.
  - frame_tick is 0.
- IDLE with enable=1: go to BLANK with digit 0. This is a frame start.
- Frame start, on the same edge:
  - Snapshot hex0_in..hex3_in and bright_in into internal registers.
  - Load seg_out from hex0_in, inverted per SEG_ACTIVE_LOW.
  - Input changes mid-frame are invisible until the next frame start.
- BLANK lasts BLANK_CYCLES clocks.
  - dig_out is inactive.
  - seg_out already holds the current digit's snapshot pattern.
  - At the end, go to ON for the same digit.
- ON lasts DIGIT_CYCLES clocks, split into 16 slots of DIGIT_CYCLES/16 clocks each.
  - dig_out selects the current digit (one-hot, per DIG_ACTIVE_LOW) in slots 0..bright_snap.
  - dig_out is inactive in the remaining slots.
  - bright_snap=15 gives full on; bright_snap=0 gives 1/16.
- End of ON, digits 0..2: index+1, go to BLANK, and load seg_out with the next digit's snapshot.
- End of ON, digit 3: pulse frame_tick, then perform a frame start (new snapshot, digit 0, BLANK).
- enable falling in any state: IDLE on the next edge; outputs inactive on that edge; no frame_tick.
- Counters:
  - Phase counter width is clog2(max(BLANK_CYCLES, DIGIT_CYCLES/16)), minimum 1.
  - Slot counter is 4 bits.
  - Counters clear on every state entry.
- No more than one dig_out bit is ever active. dig_out is never active in BLANK or IDLE.

## Timing
- All outputs are registered and change only on clk_clk rising edges, except asynchronous reset.
- Reset asserts mid-operation: outputs go inactive immediately, without waiting for a clock edge. After deassertion, the first edge with enable=1 starts a frame.
- enable sampled 1 at edge N from IDLE:
  - BLANK digit 0 runs for cycles N+1 .. N+BLANK_CYCLES.
  - ON runs for the next DIGIT_CYCLES cycles.
- Frame period is 4*(BLANK_CYCLES+DIGIT_CYCLES) clocks. frame_tick is high during the first BLANK cycle of the following frame.
- Latency from a hex input write to display: at most one frame plus one cycle.

## Test plan
Use DIGIT_CYCLES=32, BLANK_CYCLES=2 and both active-low parameters at 1 for all scenarios.

- **Reset:** assert reset_reset mid-ON with clock stopped → seg_out=8'hFF, dig_out=4'hF, frame_tick=0 immediately.
- **Full-brightness scan:**
  - Stimulus: enable=1, bright=15, hex0..3 = 3F, 06, 5B, 4F.
  - Required: digit 0 gets 2 cycles dig_out=F with seg_out=C0, then 32 cycles dig_out=E.
  - Required: digits 1..3 follow with dig_out = D/B/7 and seg_out = F9/A4/B0.
  - Required: frame_tick pulses once every 136 cycles.
- **Half brightness:** bright=7 → in each ON phase, dig_out is active for exactly the first 16 of 32 cycles and inactive for the last 16.
- **No tearing:** change hex1 from 06 to 7F while digit 0 is ON → digit 1 still shows F9 this frame; 80 appears from the next frame.
- **Enable drop:** deassert enable mid-ON of digit 2 → next edge FF/F; re-assert → restart at BLANK digit 0 with a fresh snapshot; no frame_tick emitted for the aborted frame.
- **One-hot check:** random bright_in and hex values over 50 frames → dig_out is always F or exactly one zero bit, and dig_out=F whenever in BLANK.
